// File: rtl/weight_serializer.sv
// Weight serializer: buffers sign-magnitude weights in a small FIFO and streams
// them MSB-first (sign last) with the one-cycle enable lead the multiplier needs.
module weight_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic                  flush,
    output logic                  mult_enable,
    output logic                  weight_bit,
    output logic                  result_valid,
    output logic                  busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  rv_q, rv_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign w_ready    = reset & ~fifo_full;
    assign push       = w_valid & w_ready & ~flush;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        rv_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LEAD;
            end
            ST_LEAD: begin
                // Word is rotated so the sign falls out after the magnitude bits.
                pop     = 1'b1;
                shreg_d = {head[DATA_WIDTH-2:0], head[DATA_WIDTH-1]};
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST_BIT) begin
                    rv_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = {head[DATA_WIDTH-2:0], head[DATA_WIDTH-1]};
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            rv_d    = 1'b0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            rv_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            rv_q     <= rv_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= w_data;
    end

    // Enable leads each bit by one cycle, so the sign cycle only enables if another frame follows.
    assign mult_enable  = (state_q == ST_LEAD) |
                          ((state_q == ST_SHIFT) & ((cnt_q != LAST_BIT) | ~fifo_empty));
    assign weight_bit   = (state_q == ST_SHIFT) & shreg_q[DATA_WIDTH-1];
    assign result_valid = rv_q;
    assign busy         = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_weight_serializer.sv
// Directed bench for weight_serializer: frame timing, back-to-back, backpressure,
// flush and mid-frame async reset, with an enable-lead based frame decoder.
module tb_weight_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic        flush;
    logic        mult_enable;
    logic        weight_bit;
    logic        result_valid;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    weight_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .w_data       (w_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .flush        (flush),
        .mult_enable  (mult_enable),
        .weight_bit   (weight_bit),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // A bit cycle is any cycle whose predecessor had enable high.
    logic        prev_me = 1'b0;
    int          bitcnt  = 0;
    logic [14:0] acc     = '0;
    int          rv_cnt  = 0;
    logic [15:0] got_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            prev_me <= 1'b0;
            bitcnt  <= 0;
        end else begin
            prev_me <= mult_enable;
            if (result_valid) rv_cnt <= rv_cnt + 1;
            if (prev_me) begin
                acc <= {acc[13:0], weight_bit};
                if (bitcnt == 15) begin
                    got_q.push_back({weight_bit, acc});
                    bitcnt <= 0;
                end else begin
                    bitcnt <= bitcnt + 1;
                end
            end else begin
                bitcnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        w_data  = w;
        w_valid = 1'b1;
        check("push_ready", w_ready, 1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [15:0] w, input logic more, input logic rv_first);
        logic exp_b;
        for (int k = 0; k < 16; k++) begin
            exp_b = (k == 15) ? w[15] : w[14-k];
            check($sformatf("%s_wb%0d", tag, k), weight_bit, exp_b);
            check($sformatf("%s_me%0d", tag, k), mult_enable, (k < 15) || more);
            check($sformatf("%s_rv%0d", tag, k), result_valid, (k == 0) && rv_first);
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    initial begin
        logic [15:0] words3 [4];
        logic [15:0] exp_words [8];
        int rv_before;
        int got_before;

        words3    = '{16'h8001, 16'h7FFE, 16'hC3A5, 16'h0001};
        exp_words = '{16'h8400, 16'h0400, 16'h0800, 16'h8001,
                      16'h7FFE, 16'hC3A5, 16'h0001, 16'h7FFF};

        reset   = 1'b0;
        flush   = 1'b0;
        w_valid = 1'b0;
        w_data  = '0;
        repeat (3) tick();
        check("rst_ready", w_ready, 0);
        check("rst_me", mult_enable, 0);
        check("rst_wb", weight_bit, 0);
        check("rst_rv", result_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        tick();
        check("rel_ready", w_ready, 1);

        // 1: single word, 2-cycle first-bit latency
        push(16'h8400);
        check("t1_idle_me", mult_enable, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_lead_me", mult_enable, 1);
        check("t1_lead_wb", weight_bit, 0);
        tick();
        frame("t1", 16'h8400, 1'b0, 1'b0);
        check("t1_rv_end", result_valid, 1);
        check("t1_me_end", mult_enable, 0);
        check("t1_busy_end", busy, 0);
        tick();
        check("t1_rv_once", result_valid, 0);

        // 2: back-to-back frames with a single LEAD
        push(16'h0400);
        push(16'h0800);
        check("t2_lead_me", mult_enable, 1);
        check("t2_lead_wb", weight_bit, 0);
        tick();
        frame("t2a", 16'h0400, 1'b1, 1'b0);
        frame("t2b", 16'h0800, 1'b0, 1'b1);
        check("t2_rv_end", result_valid, 1);
        check("t2_me_end", mult_enable, 0);
        tick();

        // 3: backpressure with valid held continuously
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            w_data = words3[i];
            while (!w_ready && n < 100) begin
                tick();
                n++;
            end
            check($sformatf("t3_accept%0d", i), w_ready, 1);
            tick();
            if (i == 1) check("t3_full_ready", w_ready, 0);
        end
        w_valid = 1'b0;
        wait_idle("t3_idle");

        // 4: flush at frame cycle 7 with one word queued
        push(16'h1234);
        push(16'h5678);
        tick();
        repeat (7) tick();
        check("t4_pre_me", mult_enable, 1);
        check("t4_pre_busy", busy, 1);
        rv_before  = rv_cnt;
        got_before = got_q.size();
        flush   = 1'b1;
        w_valid = 1'b1;
        w_data  = 16'hAAAA;
        tick();
        flush   = 1'b0;
        w_valid = 1'b0;
        check("t4_me", mult_enable, 0);
        check("t4_wb", weight_bit, 0);
        check("t4_ready", w_ready, 1);
        check("t4_busy", busy, 0);
        check("t4_rv", result_valid, 0);
        repeat (20) tick();
        check("t4_busy_later", busy, 0);
        check("t4_no_rv", rv_cnt, rv_before);
        check("t4_no_word", got_q.size(), got_before);

        // 5: async reset at frame cycle 10, then all-ones magnitude
        push(16'h0F0F);
        tick();
        tick();
        repeat (10) tick();
        check("t5_pre_me", mult_enable, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_me", mult_enable, 0);
        check("t5_wb", weight_bit, 0);
        check("t5_rv", result_valid, 0);
        check("t5_ready", w_ready, 0);
        check("t5_busy", busy, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("t5_rel_ready", w_ready, 1);
        check("t5_rel_busy", busy, 0);
        push(16'h7FFF);
        tick();
        tick();
        frame("t5", 16'h7FFF, 1'b0, 1'b0);
        check("t5_rv_end", result_valid, 1);
        tick();

        check("words_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_q.size()) check($sformatf("word%0d", i), got_q[i], exp_words[i]);
        end
        check("rv_total", rv_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
